wptr_full_ctl: RTL

Write-side pointer and flag controller for the asynchronous FIFO, parametrised in depth, with programmable almost-full threshold, fill level, sticky overflow, and an integrated read-pointer synchronizer. It sits in the write clock domain, drives the RAM write address, and exports the Gray write pointer to the read domain. The read domain's Gray pointer arrives raw and is synchronized internally.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/gray_sync.sv | 17 +
 rtl/wptr_full_ctl.sv | 57 +++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary conversion helpers shared by both FIFO pointer controllers
package fifo_pkg;
  localparam int GW = 32;
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    for (int i = 0; i < GW; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchronizer for a Gray-coded pointer crossing clock domains
module gray_sync #(
  parameter int WIDTH = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] sr;
  // shift the raw pointer through the chain; reset clears every stage
  always_ff @(posedge clk or negedge rst)
    if (!rst) sr <= '0;
    else sr <= {sr[STAGES-2:0], d};
  assign q = sr[STAGES-1];
endmodule

// File: rtl/wptr_full_ctl.sv
// wptr_full_ctl: write-side pointer, full/almost-full, level and overflow control of an async FIFO
module wptr_full_ctl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W:0]   r_ptr_gray,
  input  logic [ADDR_W:0]   af_thresh,
  output logic              w_inc,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W:0]   w_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   w_level,
  output logic              overflow
);
  localparam int PW = ADDR_W + 1;
  logic [ADDR_W:0] w_bin, w_bin_next, w_gray_next, rq, r_bin, level_next;
  logic full_next;
  gray_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(r_ptr_gray),
    .q(rq)
  );
  // full when the next write pointer laps the synchronized read pointer by one full depth
  always_comb begin
    r_bin = PW'(gray2bin(GW'(rq)));
    w_inc = w_en & ~full;
    w_bin_next = w_bin + PW'(w_inc);
    w_gray_next = PW'(bin2gray(GW'(w_bin_next)));
    full_next = w_gray_next == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]};
    level_next = w_bin_next - r_bin;
  end
  // pointer, flag and level registers; overflow is sticky until reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      w_bin <= '0;
      w_ptr_gray <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
      w_level <= '0;
      overflow <= 1'b0;
    end else begin
      w_bin <= w_bin_next;
      w_ptr_gray <= w_gray_next;
      full <= full_next;
      almost_full <= full_next | (level_next >= af_thresh);
      w_level <= level_next;
      overflow <= overflow | (w_en & full);
    end
  assign w_addr = w_bin[ADDR_W-1:0];
endmodule
